// File: rtl/tp_mem_stream_reader_if.sv
// rtl/tp_mem_stream_reader_if.sv - command, memory read port and output stream bundle for tp_mem_stream_reader
interface tp_mem_stream_reader_if #(
    parameter int AW   = 9,
    parameter int DW   = 16,
    parameter int LENW = 10
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_base;
    logic [LENW-1:0] cmd_len;
    logic [AW-1:0]   cmd_stride;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_rd_addr;
    logic [DW-1:0]   mem_rd_word;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            busy;
    logic            done;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, cmd_stride, mem_rd_word, out_ready,
        output cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, cmd_stride, mem_rd_word, out_ready,
        input  cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/tp_mem_stream_reader.sv
// rtl/tp_mem_stream_reader.sv - burst reader for the 512x16 user memory with credit-checked output FIFO
module tp_mem_stream_reader #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int LENW       = 10,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    tp_mem_stream_reader_if.master bus
);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   stride_q, stride_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic            inflight_q, inflight_d;
    logic            last_inflight_q, last_inflight_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            done_q, done_d;
    logic [DW:0]     fifo_q [FIFO_DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic            cmd_fire;
    logic            not_empty;
    logic [DW:0]     head;
    logic [CW:0]     outstanding;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits: words already buffered plus the read still in flight must fit the FIFO.
    assign outstanding = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue       = (state_q == RUN) && (rem_q != '0) && (outstanding < CW1'(FIFO_DEPTH));
    assign push        = inflight_q;
    assign not_empty   = (count_q != '0);
    assign head        = fifo_q[rd_ptr_q];
    assign pop         = not_empty && bus.out_ready;
    assign cmd_fire    = bus.cmd_valid && (state_q == IDLE);

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = addr_q;
    assign bus.out_valid   = not_empty;
    assign bus.out_data    = not_empty ? head[DW-1:0] : '0;
    assign bus.out_last    = not_empty ? head[DW] : 1'b0;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        stride_d        = stride_q;
        rem_d           = rem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        last_inflight_d = issue && (rem_q == LENW'(1));

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (bus.cmd_len != '0) begin
                        addr_d   = bus.cmd_base;
                        rem_d    = bus.cmd_len;
                        stride_d = bus.cmd_stride;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d = addr_q + stride_q;
                    rem_d  = rem_q - LENW'(1);
                end
                if (pop && head[DW]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            stride_q        <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            stride_q        <= stride_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            last_inflight_q <= last_inflight_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            done_q          <= done_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q says they hold data.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {last_inflight_q, bus.mem_rd_word};
    end
endmodule

// File: tb/tb_tp_mem_stream_reader.sv
// tb/tb_tp_mem_stream_reader.sv - scoreboard bench for tp_mem_stream_reader
module tb_tp_mem_stream_reader;
    localparam int AW   = 9;
    localparam int DW   = 16;
    localparam int LENW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tp_mem_stream_reader_if #(.AW(AW), .DW(DW), .LENW(LENW)) bus ();

    tp_mem_stream_reader #(.AW(AW), .DW(DW), .LENW(LENW), .FIFO_DEPTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [DW:0]   exp_beat_q [$];
    logic [AW-1:0] exp_addr_q [$];

    int issued, popped, pops, max_outst, outst;
    int first_issue, last_issue, first_pop, last_pop;
    int done_cnt, done_cyc, acc_cyc;
    bit valid_seen, stalled_prev;
    logic [DW:0] prev_word;

    function automatic logic [DW-1:0] memval(input int a);
        return 16'((a * 37) ^ 16'hC35A);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro model: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_word <= memval(int'(bus.mem_rd_addr));
    end

    // Monitor: samples on the falling edge and pops the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            outst = issued - popped;
            if (outst > max_outst) max_outst = outst;
            if (bus.mem_rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL rd_addr: unexpected read of %0d", bus.mem_rd_addr);
                end else begin
                    check("rd_addr", 32'(bus.mem_rd_addr), 32'(exp_addr_q.pop_front()));
                end
                issued++;
                if (first_issue < 0) first_issue = cyc;
                last_issue = cyc;
            end
            if (bus.out_valid) valid_seen = 1'b1;
            if (stalled_prev) check("stall_hold", {bus.out_last, bus.out_data}, 32'(prev_word));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_beat_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL beat: unexpected word %0h", bus.out_data);
                end else begin
                    check("beat", {bus.out_last, bus.out_data}, 32'(exp_beat_q.pop_front()));
                end
                popped++;
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            prev_word    = {bus.out_last, bus.out_data};
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc + 1;
        end
    end

    task automatic start_test();
        issued = 0; popped = 0; pops = 0; max_outst = 0;
        first_issue = -1; last_issue = -1; first_pop = -1; last_pop = -1;
        done_cnt = 0; done_cyc = -1; acc_cyc = -1; valid_seen = 1'b0;
    endtask

    task automatic send_cmd(input int base, input int len, input int stride);
        int a;
        int k;
        for (k = 0; k < 100 && !bus.cmd_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!bus.cmd_ready) begin
            n_checks++; n_err++;
            $display("FAIL cmd_ready: timeout got 0 expected 1");
        end
        a = base;
        for (int i = 0; i < len; i++) begin
            exp_addr_q.push_back(AW'(a));
            exp_beat_q.push_back({(i == len - 1), memval(a)});
            a = (a + stride) % 512;
        end
        bus.cmd_base   = AW'(base);
        bus.cmd_len    = LENW'(len);
        bus.cmd_stride = AW'(stride);
        bus.cmd_valid  = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        if (done_cnt == 0) begin
            n_checks++; n_err++;
            $display("FAIL %s: done timeout got 0 expected 1", name);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 200 && pops < n; i++) begin
            @(posedge clk); #1;
        end
        if (pops < n) begin
            n_checks++; n_err++;
            $display("FAIL wait_pops: got %0d expected %0d", pops, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        check({tag, "_mem_rd_en"}, 32'(bus.mem_rd_en), 0);
        check({tag, "_mem_rd_addr"}, 32'(bus.mem_rd_addr), 0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_data"}, 32'(bus.out_data), 0);
        check({tag, "_out_last"}, 32'(bus.out_last), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
    endtask

    task automatic end_of_burst(input string tag);
        check({tag, "_done_count"}, 32'(done_cnt), 1);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        check({tag, "_beats_left"}, 32'(exp_beat_q.size()), 0);
        check({tag, "_reads_left"}, 32'(exp_addr_q.size()), 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_len    = '0;
        bus.cmd_stride = '0;
        bus.out_ready  = 1'b1;
        start_test();
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Contiguous burst: latency and back-to-back throughput.
        start_test();
        send_cmd(0, 4, 1);
        wait_done("t1");
        end_of_burst("t1");
        check("t1_first_issue", 32'(first_issue), 32'(acc_cyc));
        check("t1_issue_span", 32'(last_issue - first_issue), 3);
        check("t1_first_beat", 32'(first_pop), 32'(acc_cyc + 2));
        check("t1_beat_span", 32'(last_pop - first_pop), 3);
        check("t1_done_cycle", 32'(done_cyc), 32'(last_pop + 1));

        start_test();
        send_cmd(510, 4, 1);
        wait_done("t2");
        end_of_burst("t2");

        start_test();
        send_cmd(5, 4, 128);
        wait_done("t3");
        end_of_burst("t3");

        // Backpressure after the first beat.
        start_test();
        send_cmd(20, 8, 3);
        wait_pops(1);
        bus.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_done("t4");
        end_of_burst("t4");
        check("t4_max_outstanding", 32'(max_outst), 3);
        check("t4_beats", 32'(pops), 8);
        check("t4_issue_gap", 32'(last_issue - first_issue > 7), 1);

        start_test();
        send_cmd(7, 0, 1);
        wait_done("t5");
        end_of_burst("t5");
        check("t5_no_read", 32'(issued), 0);
        check("t5_no_valid", 32'(valid_seen), 0);
        check("t5_done_cycle", 32'(done_cyc), 32'(acc_cyc));

        // Reset in the middle of a long burst, then a clean short burst.
        start_test();
        send_cmd(0, 16, 1);
        wait_pops(2);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_beat_q.delete();
        exp_addr_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        start_test();
        send_cmd(100, 2, 1);
        wait_done("t6");
        end_of_burst("t6");
        check("t6_beats", 32'(pops), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/tp_mem_stream_reader.md
Name: tp_mem_stream_reader

Overview:
Read-side initiator for the 512x16 two-port user memory (four 128x16 banks selected by address bits [8:7]). It accepts a burst command (base, length, stride), drives the memory read port, and absorbs the macro's 1-cycle read latency. Read data is returned as a valid/ready stream through a small credit-checked FIFO, so downstream backpressure never drops or duplicates a word. It sits between the MVU sequencing logic and the memory read port; the write port is untouched.

Parameters:
AW, 9, memory address width (512 words)
DW, 16, memory word width
LENW, 10, burst length field width (0..1023 words)
FIFO_DEPTH, 3, output FIFO entries; minimum 3 for 1 word/cycle throughput

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  high only in IDLE
cmd_base  in  AW  first read address
cmd_len  in  LENW  number of words to read
cmd_stride  in  AW  address increment per word, modulo 2^AW
mem_rd_en  out  1  memory read enable, active-high
mem_rd_addr  out  AW  memory read address
mem_rd_word  in  DW  memory read data, valid the cycle after mem_rd_en
out_valid  out  1  stream data valid
out_ready  in  1  stream consumer ready
out_data  out  DW  stream data
out_last  out  1  marks final word of burst
busy  out  1  high in RUN
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high. On reset, all state clears immediately: state=IDLE, FIFO empty, in-flight flag 0. Resulting outputs: cmd_ready=1, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- States: IDLE, RUN.
- IDLE: cmd_ready=1.
  - On cmd_valid&cmd_ready with len>0: latch addr=base, remaining=len, stride; go to RUN.
  - With len=0: no reads issued; done=1 on the next cycle; stay IDLE.
- RUN issue rule: mem_rd_en = (remaining>0) && (fifo_count + inflight_q < FIFO_DEPTH).
  - inflight_q is mem_rd_en registered.
  - mem_rd_en and mem_rd_addr are combinational from registered state only; there is no path from out_ready.
  - mem_rd_addr = current addr.
  - On issue: addr <= (addr + stride) mod 2^AW; remaining decrements.
- Capture: when inflight_q=1, write {last, mem_rd_word} into the FIFO at the end of that cycle. last=1 for the word issued with remaining==1.
- Latency:
  - Command accepted at edge k: mem_rd_en is high in the cycle after edge k, and out_valid rises after edge k+2.
  - Steady state with out_ready held high: one word per cycle, no bubbles.
- Output: out_valid = FIFO not empty; out_data/out_last = FIFO head. Head is stable while out_valid && !out_ready.
- FIFO full/empty: push and pop in the same cycle are both legal, including when the FIFO is full. The credit rule guarantees no push ever occurs into a full FIFO with no pop.
- Completion: pop of the word with out_last=1 gives done=1 for one cycle and returns the state to IDLE on the same edge; cmd_ready is high the next cycle.
- No new command is accepted while in RUN; cmd_valid is ignored until IDLE.
- Wrap-around: addresses wrap modulo 512 across bank boundaries transparently. Lengths >512 re-read wrapped addresses.
- Reset mid-burst: the in-flight read is discarded, the FIFO is flushed, and mem_rd_en drops asynchronously with the state registers. The next command after reset behaves exactly as from power-up.

Test Plan:
- base=0, stride=1, len=4, out_ready=1 -> mem_rd_addr 0,1,2,3 on consecutive cycles; 4 data beats back-to-back; out_last on beat 4 only; done pulses once; cmd_ready returns to 1.
- base=510, stride=1, len=4 -> addresses 510,511,0,1; data matches preloaded memory contents across the bank-3 to bank-0 wrap.
- base=5, stride=128, len=4 -> addresses 5,133,261,389 (one per bank); correct data and order.
- len=8, out_ready low for 6 cycles after the first beat -> outstanding words (fifo_count + inflight) never exceed 3; mem_rd_en deasserts; out_data stable while stalled; all 8 words delivered exactly once, in order.
- len=0 -> mem_rd_en never asserts, out_valid never asserts; done high exactly one cycle after acceptance.
- rst asserted for 1 cycle during beat 3 of a len=16 burst -> all outputs at reset values immediately; a following base=100, len=2 command returns the words at 100 and 101 with no stale data.
